// File: rtl/result_stream_out_pkg.sv
// Shared fixed-point helpers for the result_stream_out block and later stages.
// Provides rso_sat(): round-half-up right shift followed by signed saturation.
package result_stream_out_pkg;

   localparam int rso_max_w = 64;

   typedef struct packed {
      logic                 sat;
      logic [rso_max_w:0]   data;
   } rso_res_t;

   // v is the sign-extended input; result is sign-extended to rso_max_w+1 bits
   function automatic rso_res_t rso_sat(
      input logic signed [rso_max_w-1:0] v,
      input int unsigned                 shift,
      input int unsigned                 out_w
   );
      rso_res_t                   res;
      logic signed [rso_max_w:0]  t;
      logic signed [rso_max_w:0]  hi;
      logic signed [rso_max_w:0]  lo;
      t  = ($signed({v[rso_max_w-1], v}) + (65'sd1 <<< (shift - 1))) >>> shift;
      hi = (65'sd1 <<< (out_w - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (out_w - 1));
      res.sat = 1'b0;
      res.data = t;
      if (t > hi) begin
         res.data = hi;
         res.sat  = 1'b1;
      end else if (t < lo) begin
         res.data = lo;
         res.sat  = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/result_stream_out_if.sv
// Output stream of result_stream_out: show-ahead data with valid/ready.
// master drives out_data/out_valid, slave drives out_ready.
interface result_stream_out_if #(
   parameter int out_w = 16
);
   logic [out_w-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/result_stream_out_sync_fifo.sv
// Show-ahead synchronous FIFO, no write-to-read bypass.
// Ports: wr_valid/wr_data in, rd_ready in, rd_data/level/full/empty out.
module result_stream_out_sync_fifo #(
   parameter int width = 16,
   parameter int depth = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_valid,
   input  logic [width-1:0]         wr_data,
   input  logic                     rd_ready,
   output logic [width-1:0]         rd_data,
   output logic [$clog2(depth):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int aw = $clog2(depth);
   localparam logic [aw:0] cap = (aw + 1)'(depth);

   logic [width-1:0] mem [depth];
   logic [aw-1:0]    wptr;
   logic [aw-1:0]    rptr;
   logic [aw:0]      cnt;
   logic             do_rd;
   logic             do_wr;

   assign empty = (cnt == '0);
   assign full  = (cnt == cap);
   assign level = cnt;
   assign do_rd = !empty && rd_ready;
   // a read in the same cycle frees the slot, so writing at full is legal
   assign do_wr = wr_valid && (!full || do_rd);
   // forced to zero while empty so reset presents a clean bus
   assign rd_data = empty ? '0 : mem[rptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
         unique case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= wr_data;
   end

endmodule

// File: rtl/result_stream_out.sv
// Output stage for the batch filter: round/saturate results, buffer, stream out.
// Ports: clk, rst (async low), in/in_valid, o (stream), level, sat, overflow, clear.
module result_stream_out
   import result_stream_out_pkg::*;
#(
   parameter int in_w  = 24,
   parameter int out_w = 16,
   parameter int shift = 8,
   parameter int depth = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [in_w-1:0]   in,
   input  logic                     in_valid,
   result_stream_out_if.master      o,
   output logic [$clog2(depth):0]   level,
   output logic                     sat,
   output logic                     overflow,
   input  logic                     clear
);
   rso_res_t          r;
   logic              fits;
   logic              set_sat;
   logic              set_ovf;
   logic              p_valid;
   logic [out_w-1:0]  p_data;
   logic              full;
   logic              empty;

   always_comb begin
      r = rso_sat({{(rso_max_w - in_w){in[in_w-1]}}, in},
                  shift, out_w);
   end

   // the converted word must be a pure sign extension of its out_w LSBs
   assign fits = (r.data[rso_max_w:out_w-1] ==
                  {(rso_max_w + 2 - out_w){r.data[out_w-1]}});
   assign set_sat = in_valid && (r.sat || !fits);
   assign set_ovf = p_valid && full && !(o.out_valid && o.out_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_valid <= 1'b0;
         p_data  <= '0;
      end else begin
         p_valid <= in_valid;
         if (in_valid) p_data <= r.data[out_w-1:0];
      end
   end

   // set wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat      <= 1'b0;
         overflow <= 1'b0;
      end else begin
         sat      <= set_sat || (sat && !clear);
         overflow <= set_ovf || (overflow && !clear);
      end
   end

   result_stream_out_sync_fifo #(
      .width (out_w),
      .depth (depth)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (p_valid),
      .wr_data  (p_data),
      .rd_ready (o.out_ready),
      .rd_data  (o.out_data),
      .level    (level),
      .full     (full),
      .empty    (empty)
   );

   assign o.out_valid = !empty;

endmodule

// File: doc/result_stream_out.md
# result_stream_out

Downstream output stage for the batch fixed-point filter. It takes the filter's `out`/`valid` result stream, one word every DSR clocks, and converts each result to a narrower signed word. Conversion drops `shift` LSBs with round-half-up and then saturates to `out_w` bits. Converted words are buffered in a small FIFO and presented to the consumer over a valid/ready handshake. Sticky flags report saturation and dropped samples.

## Interface
Parameters:
- `in_w`, 24: width of the filter result (matches the filter's OUT_WIDTH); signed two's complement.
- `out_w`, 16: output word width; must satisfy out_w + shift ≤ in_w.
- `shift`, 8: number of LSBs discarded; must be ≥ 1.
- `depth`, 16: FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous, active-low reset.
- `in`  in  in_w  filter result.
- `in_valid`  in  1  `in` is valid this cycle; single-cycle pulses.
- `out_data`  out  out_w  FIFO head word.
- `out_valid`  out  1  FIFO is non-empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `level`  out  $clog2(depth)+1  number of words currently stored.
- `sat`  out  1  sticky: at least one result was saturated.
- `overflow`  out  1  sticky: at least one converted word was dropped because the FIFO was full.
- `clear`  in  1  synchronous clear of `sat` and `overflow` only.

## Operation
- **Stage 1 (convert):**
  - On `in_valid`, form t = sext(in, in_w+1) + 2^(shift-1), then arithmetic right shift by `shift`.
  - If t > 2^(out_w-1)-1, output 0x7FF…F. If t < -2^(out_w-1), output 0x800…0. In either case set `sat`.
  - Register the result as `p_data` and `p_valid`. `p_valid` is a copy of `in_valid` delayed by one cycle.
- **Stage 2 (FIFO):**
  - Storage is `depth` words, with a write pointer, a read pointer and a count.
  - Pointers are $clog2(depth) bits wide and wrap naturally.
  - Write condition: `p_valid` and (not full, or a read occurs in the same cycle).
  - Full with no read and `p_valid` high: the word is discarded, pointers are unchanged, and `overflow` is set.
  - Read condition: `out_valid` and `out_ready`. `out_ready` while empty has no effect.
  - Simultaneous read and write: `level` is unchanged. This is legal at full and at any other level.
  - Write into an empty FIFO: there is no bypass; the word becomes visible the next cycle.
- **Outputs:**
  - `out_data` is the memory word at the read pointer (show-ahead).
  - `out_valid` = (`level` ≠ 0).
  - `out_data` must hold stable while `out_valid` is high and `out_ready` is low.
- **Flags:**
  - `sat` and `overflow` are cleared by `clear`.
  - If `clear` and a set event occur in the same cycle, set wins.

## Timing
- Reset values (async assert, sync deassert is handled externally):
  - `out_valid`=0, `level`=0, `sat`=0, `overflow`=0, `out_data`=0.
  - Pointers=0, `p_valid`=0. Memory contents are not reset.
- Latency: `in_valid` sampled at edge k gives `p_valid` after edge k; the FIFO write happens at edge k+1; `out_valid` is high after edge k+1. That is 2 cycles from input to availability when the FIFO is not full.
- Throughput: one word per cycle in and out; `in_valid` back-to-back is legal.
- Reset asserted mid-operation:
  - All stored words are lost.
  - The in-flight `p_valid` word is discarded.
  - Flags clear; `out_valid` drops immediately (asynchronously).

## Structure
- Shared package holds `rso_sat(in, shift, out_w)`, a rounding/saturation function returning the converted word and a saturation bit, reusable by later fixed-point stages.
- One sub-module is natural: `sync_fifo` (show-ahead, parameters `width`/`depth`, outputs `level`/`full`/`empty`).
- Stage 1 and the flag logic stay in the top module.

## Test plan
1. **Rounding:** in=0x000180 → out_data=0x0002; in=0xFFFE80 → 0xFFFF; in=0x000080 → 0x0001. `sat` stays 0.
2. **Saturation:**
   - in=0x7FFFFF → 0x7FFF and `sat`=1.
   - in=0x800000 → 0x8000 with `sat` unchanged.
   - `clear` pulse → `sat`=0.
3. **Latency and back-to-back:**
   - `in_valid` at edge 0 → `out_valid` high after edge 1.
   - 4 consecutive inputs with `out_ready`=1 → 4 words out in order, one per cycle; `level` ≤ 2.
4. **Full/overflow:**
   - `out_ready`=0; 17 inputs with depth=16 → `level`=16, `overflow`=1.
   - Then read all → exactly the first 16 words; the 17th is absent.
5. **Simultaneous at full:** at `level`=16, `p_valid` and `out_ready` both high → `level` stays 16, `overflow` stays 0, and the new word appears after 16 reads.
6. **Reset mid-stream:** `level`=5, then `rst` low for 1 cycle → `out_valid`=0, `level`=0, flags 0. A subsequent input reappears 2 cycles later.
